mdr_beat_engine: RTL and testbench

Parametrised memory data register that holds one WORD_W-bit data word between the memory interface and the datapath. It accepts direct single-cycle writes of a narrow beat (zero- or sign-extended) or a full word. It also runs multi-beat transfers: a serial load assembles a word from BEATS narrow memory beats, and a serial store emits the held word as BEATS beats under a valid/ready handshake. It replaces the fixed two-width data register on the processor's memory path.

---
 rtl/mdr_beat_engine.sv | 129 ++++++++++++
 tb/tb_mdr_beat_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdr_beat_engine.sv
// Memory data register: holds one WORD_W-bit word. Supports direct narrow/wide writes,
// and multi-beat serial load (assemble) and serial store (emit under valid/ready).
module mdr_beat_engine #(
  parameter int BEAT_W = 9,
  parameter int BEATS  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_narrow,
  input  logic [BEAT_W-1:0]         din_narrow,
  input  logic                      sext,
  input  logic                      wr_wide,
  input  logic [BEAT_W*BEATS-1:0]   din_wide,
  input  logic                      ld_start,
  input  logic                      mem_valid,
  input  logic [BEAT_W-1:0]         mem_data,
  input  logic                      st_start,
  input  logic                      st_ready,
  output logic                      st_valid,
  output logic [BEAT_W-1:0]         st_data,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [BEAT_W-1:0]         dout_narrow,
  output logic [BEAT_W*BEATS-1:0]   dout_wide
);

  localparam int WORD_W = BEAT_W * BEATS;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   shadow;
  logic [WORD_W-1:0]   shadow_nx;
  logic [WORD_W-1:0]   snap;

  function automatic logic [WORD_W-1:0] ext_narrow(
    input logic signed [BEAT_W-1:0] d,
    input logic                     sx
  );
    logic signed [WORD_W-1:0] s;
    s = d;
    return sx ? $unsigned(s) : {{(WORD_W-BEAT_W){1'b0}}, $unsigned(d)};
  endfunction

  // Shadow plus the beat arriving this cycle; the last beat commits straight from here.
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[cnt*BEAT_W +: BEAT_W] = mem_data;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && mem_valid && !abort)
      shadow <= shadow_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dout_wide <= '0;
      snap      <= '0;
      st_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wr_wide)
            dout_wide <= din_wide;
          else if (wr_narrow)
            dout_wide <= ext_narrow(din_narrow, sext);
          else if (ld_start)
            state <= LOAD;
          else if (st_start) begin
            state    <= STORE;
            snap     <= dout_wide;
            st_valid <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (mem_valid) begin
            if (cnt == LAST) begin
              dout_wide <= shadow_nx;
              state     <= IDLE;
              cnt       <= '0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        STORE: begin
          if (abort) begin
            state    <= IDLE;
            cnt      <= '0;
            st_valid <= 1'b0;
          end else if (st_ready) begin
            if (cnt == LAST) begin
              state    <= IDLE;
              cnt      <= '0;
              st_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          st_valid <= 1'b0;
        end
      endcase
    end
  end

  assign st_data     = snap[cnt*BEAT_W +: BEAT_W];
  assign busy        = (state != IDLE);
  assign dout_narrow = dout_wide[BEAT_W-1:0];

endmodule

// File: tb/tb_mdr_beat_engine.sv
// Directed bench for mdr_beat_engine with a queue scoreboard for loaded words and stored beats.
module tb_mdr_beat_engine;

  localparam int BW = 9;
  localparam int NB = 2;
  localparam int WW = BW * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_narrow, sext, wr_wide, ld_start, mem_valid, st_start, st_ready, abort;
  logic [BW-1:0] din_narrow, mem_data, st_data, dout_narrow;
  logic [WW-1:0] din_wide, dout_wide;
  logic          st_valid, busy, done;

  logic          b_rst_n, b_wr_narrow, b_sext, b_wr_wide, b_ld_start, b_mem_valid;
  logic          b_st_start, b_st_ready, b_abort, b_st_valid, b_busy, b_done;
  logic [7:0]    b_din_narrow, b_mem_data, b_st_data, b_dout_narrow;
  logic [31:0]   b_din_wide, b_dout_wide;

  mdr_beat_engine #(.BEAT_W(BW), .BEATS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_narrow(wr_narrow), .din_narrow(din_narrow), .sext(sext),
    .wr_wide(wr_wide), .din_wide(din_wide), .ld_start(ld_start), .mem_valid(mem_valid),
    .mem_data(mem_data), .st_start(st_start), .st_ready(st_ready), .st_valid(st_valid),
    .st_data(st_data), .abort(abort), .busy(busy), .done(done),
    .dout_narrow(dout_narrow), .dout_wide(dout_wide)
  );

  mdr_beat_engine #(.BEAT_W(8), .BEATS(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .wr_narrow(b_wr_narrow), .din_narrow(b_din_narrow), .sext(b_sext),
    .wr_wide(b_wr_wide), .din_wide(b_din_wide), .ld_start(b_ld_start), .mem_valid(b_mem_valid),
    .mem_data(b_mem_data), .st_start(b_st_start), .st_ready(b_st_ready), .st_valid(b_st_valid),
    .st_data(b_st_data), .abort(b_abort), .busy(b_busy), .done(b_done),
    .dout_narrow(b_dout_narrow), .dout_wide(b_dout_wide)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb_word[$];
  logic [31:0] sb_beat[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (sb_word.size() != 0) ? sb_word.pop_front() : 32'hx;
    chk(tag, obs, e);
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (sb_beat.size() != 0) ? sb_beat.pop_front() : 32'hx;
    chk(tag, obs, e);
  endtask

  initial begin
    logic [WW-1:0] w;
    rst_n = 0; wr_narrow = 0; sext = 0; wr_wide = 0; ld_start = 0; mem_valid = 0;
    st_start = 0; st_ready = 0; abort = 0; din_narrow = '0; mem_data = '0; din_wide = '0;
    b_rst_n = 0; b_wr_narrow = 0; b_sext = 0; b_wr_wide = 0; b_ld_start = 0; b_mem_valid = 0;
    b_st_start = 0; b_st_ready = 0; b_abort = 0; b_din_narrow = '0; b_mem_data = '0; b_din_wide = '0;
    tick(); tick();
    chk("rst_dout_wide", dout_wide, 0);
    chk("rst_dout_narrow", dout_narrow, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_data", st_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;

    wr_narrow = 1; din_narrow = 9'h1A5; sext = 1;
    tick();
    chk("narrow_sext_wide", dout_wide, 18'h3FFA5);
    chk("narrow_sext_narrow", dout_narrow, 9'h1A5);
    sext = 0;
    tick();
    wr_narrow = 0;
    chk("narrow_zext_wide", dout_wide, 18'h001A5);

    wr_wide = 1; wr_narrow = 1; din_wide = 18'h2AAAA; ld_start = 1; st_start = 1;
    tick();
    wr_wide = 0; wr_narrow = 0; ld_start = 0; st_start = 0;
    chk("wide_over_narrow", dout_wide, 18'h2AAAA);
    chk("write_blocks_start", busy, 0);

    // Serial load with a stall between beats
    ld_start = 1; mem_valid = 1; mem_data = 9'h1FF;
    sb_word.push_back(32'h2AAF0);
    tick();
    ld_start = 0; mem_data = 9'h0F0;
    chk("ld_busy", busy, 1);
    chk("ld_start_beat_ignored", dout_wide, 18'h2AAAA);
    tick();
    mem_valid = 0;
    chk("ld_partial_hidden", dout_wide, 18'h2AAAA);
    chk("ld_no_early_done", done, 0);
    tick();
    mem_valid = 1; mem_data = 9'h155;
    chk("ld_stall_hidden", dout_wide, 18'h2AAAA);
    tick();
    mem_valid = 0;
    chk("ld_done", done, 1);
    chk("ld_idle", busy, 0);
    chk_word("ld_word", dout_wide);
    tick();
    chk("ld_done_one_cycle", done, 0);

    // Serial store with back-pressure on beat 0
    w = 18'h2AAF0;
    st_start = 1; st_ready = 0;
    sb_beat.push_back(32'(w[8:0]));
    sb_beat.push_back(32'(w[17:9]));
    tick();
    st_start = 0;
    chk("st_valid_first", st_valid, 1);
    chk("st_hold_a", st_data, 9'h0F0);
    tick();
    chk("st_hold_b", st_data, 9'h0F0);
    tick();
    chk("st_hold_c", st_data, 9'h0F0);
    chk("st_valid_hold", st_valid, 1);
    st_ready = 1;
    chk_beat("st_beat0", st_data);
    tick();
    chk("st_valid_beat1", st_valid, 1);
    chk_beat("st_beat1", st_data);
    tick();
    st_ready = 0;
    chk("st_valid_end", st_valid, 0);
    chk("st_done", done, 1);
    chk("st_idle", busy, 0);
    chk("st_dout_kept", dout_wide, 18'h2AAF0);

    // Start in the done cycle, then abort after one beat
    ld_start = 1;
    tick();
    ld_start = 0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_clear", done, 0);
    mem_valid = 1; mem_data = 9'h0AB;
    tick();
    mem_valid = 0; abort = 1;
    tick();
    abort = 0;
    chk("abort_idle", busy, 0);
    chk("abort_no_done", done, 0);
    chk("abort_dout_kept", dout_wide, 18'h2AAF0);
    tick();
    chk("abort_no_done_late", done, 0);

    // Both starts: load wins; wide write during load ignored
    ld_start = 1; st_start = 1;
    tick();
    ld_start = 0; st_start = 0;
    chk("both_busy", busy, 1);
    chk("both_is_load", st_valid, 0);
    wr_wide = 1; din_wide = '0; mem_valid = 1; mem_data = 9'h012;
    sb_word.push_back(32'({9'h034, 9'h012}));
    tick();
    wr_wide = 0; mem_data = 9'h034;
    chk("wr_during_load", dout_wide, 18'h2AAF0);
    tick();
    mem_valid = 0;
    chk("ld2_done", done, 1);
    chk_word("ld2_word", dout_wide);

    // Reset in the middle of a store
    st_start = 1;
    tick();
    st_start = 0; st_ready = 1;
    tick();
    st_ready = 0;
    chk("st2_beat1", st_data, 9'h034);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mrst_dout_wide", dout_wide, 0);
    chk("mrst_dout_narrow", dout_narrow, 0);
    chk("mrst_st_valid", st_valid, 0);
    chk("mrst_st_data", st_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);

    // Wider configuration: four 8-bit beats at full rate
    b_rst_n = 1;
    b_ld_start = 1;
    tick();
    b_ld_start = 0; b_mem_valid = 1;
    sb_word.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      b_mem_data = 8'((i + 1) * 17);
      tick();
      if (i < 3) chk("b_partial_hidden", b_dout_wide, 0);
    end
    b_mem_valid = 0;
    chk("b_done", b_done, 1);
    chk_word("b_word", b_dout_wide);
    chk("b_narrow", b_dout_narrow, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
